qerv_stdata: RTL and testbench
==============================

QERV_STDATA -- requirements
Module: qerv_stdata

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; both are listed below.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_rst  input  1  synchronous active-high reset.
REQ-004 i_start  input  1  one-cycle store request; sampled only in IDLE.
REQ-005 i_cnt_en  input  1  nibble strobe; one datapath nibble is valid this cycle.
REQ-006 i_cnt_done  input  1  marks the last nibble of the stream; valid only with i_cnt_en.
REQ-007 i_dat  input  4  store-data nibble, LSB nibble first.
REQ-008 i_size  input  2  transfer size, sampled with i_start: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-009 i_lsb  input  2  address bits [1:0], sampled with i_start.
REQ-010 o_wb_stb  output  1  write request strobe.
REQ-011 o_wb_dat  output  32  lane-replicated write data.
REQ-012 o_wb_sel  output  4  byte-lane select.
REQ-013 i_wb_ack  input  1  write acknowledge.
REQ-014 o_busy  output  1  high in any state other than IDLE.
REQ-015 o_done  output  1  one-cycle pulse when the bus write completes.
REQ-016 o_misalign  output  1  one-cycle pulse when a store is dropped for misalignment.

Function
REQ-017 FSM states SHALL be IDLE, FILL and REQ.
REQ-018 IDLE with i_start=1: the block SHALL latch i_size and i_lsb, clear the 3-bit nibble counter, and go to FILL next cycle.
REQ-019 i_cnt_en SHALL be ignored in IDLE and REQ; in IDLE, an i_cnt_en coincident with i_start is not captured.
REQ-020 FILL with i_cnt_en=1: data SHALL shift as data <= {i_dat, data[31:4]}, and the counter SHALL increment, wrapping modulo 8.
REQ-021 FILL with i_cnt_en=1 and i_cnt_done=1: the nibble SHALL be captured, and the next state SHALL be REQ if aligned, otherwise IDLE with o_misalign=1 for exactly one cycle.
REQ-022 Alignment rules:
  - byte: always aligned;
  - half: requires i_lsb[0]=0;
  - word: requires i_lsb=00.
REQ-023 i_cnt_done SHALL alone terminate FILL; a stream with fewer than 8 nibbles leaves upper nibbles holding stale shifted contents (no error).
REQ-024 o_wb_stb SHALL be registered and high for every cycle in REQ; o_wb_dat and o_wb_sel SHALL be stable throughout REQ.
REQ-025 o_wb_dat: byte = {4{d[7:0]}}, half = {2{d[15:0]}}, word = d.
REQ-026 o_wb_sel: byte = 4'b0001<<i_lsb, half = i_lsb[1] ? 4'b1100 : 4'b0011, word = 4'b1111; o_wb_sel SHALL be 0 outside REQ.
REQ-027 REQ with i_wb_ack=1: the block SHALL return to IDLE and pulse o_done for one cycle, the cycle after the ack; o_wb_stb SHALL be low that cycle.
REQ-028 An ack arriving on the first REQ cycle SHALL complete the transfer (minimum REQ duration 1 cycle); i_wb_ack outside REQ SHALL be ignored.
REQ-029 i_start outside IDLE SHALL be ignored; the store is not queued.
REQ-030 Latency: the last nibble at cycle N gives o_wb_stb=1 at N+1; an ack at cycle M gives o_done=1 at M+1.

Reset
REQ-031 i_rst=1 SHALL, at the next edge, force IDLE, set o_wb_stb=0, o_done=0, o_misalign=0, data=0, counter=0, size=10 and lsb=00, overriding all other inputs.
REQ-032 Reset mid-FILL or mid-REQ SHALL abort the store without a o_done pulse; o_wb_stb SHALL drop on the cycle after reset is sampled.

Structure
REQ-033 Package qerv_pkg SHALL hold the FSM state enum and the size encodings (QERV_SZ_B, QERV_SZ_H, QERV_SZ_W).
REQ-034 Lane replication and select generation SHALL be a combinational sub-module, qerv_stdata_lane, with inputs size, lsb and data and outputs dat and sel.

Verification
REQ-035 Word store: start size=10 lsb=00, nibbles 0x8,7,6,5,4,3,2,1 (done on the 8th), ack 2 cycles later -> o_wb_dat=0x12345678, sel=1111, stb held 3 cycles, o_done one pulse.
REQ-036 Byte store: size=00 lsb=11, nibbles 0xA,0x5,0,0,0,0,0,0 -> o_wb_dat=0x5A5A5A5A, sel=1000.
REQ-037 Half store: size=01 lsb=10, data 0x0000BEEF -> o_wb_dat=0xBEEFBEEF, sel=1100; a second run with lsb=01 -> o_misalign pulse, stb never asserted, returns to IDLE.
REQ-038 Same-cycle ack: ack held high continuously -> stb high exactly 1 cycle, o_done at the next cycle; i_start during FILL ignored (the counter is undisturbed).
REQ-039 Reset after the 4th nibble, then a fresh word store of 0xCAFEF00D -> o_wb_dat=0xCAFEF00D, with no residue of the aborted store and no o_done from the aborted store.

Source files
------------

// File: rtl/qerv_stdata_pkg.sv
// Shared types for the nibble-serial store-data unit: FSM states, transfer
// size encodings and the alignment rule used to accept or drop a store.
package qerv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      REQ  = 2'd2
   } state_e;

   localparam logic [1:0] QERV_SZ_B = 2'b00;
   localparam logic [1:0] QERV_SZ_H = 2'b01;
   localparam logic [1:0] QERV_SZ_W = 2'b10;

   // The reserved size 2'b11 falls into the default arm and is handled as a word.
   function automatic logic qerv_aligned(input logic [1:0] size, input logic [1:0] lsb);
      logic ok;
      case (size)
         QERV_SZ_B: ok = 1'b1;
         QERV_SZ_H: ok = ~lsb[0];
         default:   ok = (lsb == 2'b00);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/qerv_stdata_if.sv
// Write-side bus between the store-data unit (master) and memory (slave).
interface qerv_stdata_if;

   logic        o_wb_stb;
   logic [31:0] o_wb_dat;
   logic [3:0]  o_wb_sel;
   logic        i_wb_ack;

   modport master (output o_wb_stb, output o_wb_dat, output o_wb_sel, input i_wb_ack);
   modport slave  (input o_wb_stb, input o_wb_dat, input o_wb_sel, output i_wb_ack);

endinterface

// File: rtl/qerv_stdata_lane.sv
// Combinational lane steering: replicates the low bytes of the store word
// across the bus and builds the matching byte-lane select.
module qerv_stdata_lane
   import qerv_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  lsb_i,
   input  logic [31:0] data_i,
   output logic [31:0] dat_o,
   output logic [3:0]  sel_o
);

   always_comb begin
      dat_o = data_i;
      sel_o = 4'b1111;
      case (size_i)
         QERV_SZ_B: begin
            dat_o = {4{data_i[7:0]}};
            sel_o = 4'b0001 << lsb_i;
         end
         QERV_SZ_H: begin
            dat_o = {2{data_i[15:0]}};
            sel_o = lsb_i[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            dat_o = data_i;
            sel_o = 4'b1111;
         end
      endcase
   end

endmodule

// File: rtl/qerv_stdata.sv
// Store-data unit: collects store data one nibble at a time, checks alignment,
// then holds a lane-replicated bus write until the acknowledge arrives.
module qerv_stdata
   import qerv_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_cnt_en,
   input  logic                 i_cnt_done,
   input  logic [3:0]           i_dat,
   input  logic [1:0]           i_size,
   input  logic [1:0]           i_lsb,
   qerv_stdata_if.master        wb,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_misalign
);

   state_e      state_q;
   logic [31:0] data_q;
   logic [31:0] data_d;
   logic [2:0]  cnt_q;
   logic [2:0]  cnt_d;
   logic [1:0]  size_q;
   logic [1:0]  lsb_q;
   logic        stb_q;
   logic        done_q;
   logic        misalign_q;
   logic [31:0] laneDat;
   logic [3:0]  laneSel;

   assign data_d = {i_dat, data_q[31:4]};
   assign cnt_d  = cnt_q + 3'd1;

   // Nothing moves data_q during REQ, so the bus word stays stable until the ack.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         data_q     <= '0;
         cnt_q      <= '0;
         size_q     <= QERV_SZ_W;
         lsb_q      <= 2'b00;
         stb_q      <= 1'b0;
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  size_q  <= i_size;
                  lsb_q   <= i_lsb;
                  cnt_q   <= '0;
                  state_q <= FILL;
               end
            end
            FILL: begin
               if (i_cnt_en) begin
                  data_q <= data_d;
                  cnt_q  <= cnt_d;
                  if (i_cnt_done) begin
                     if (qerv_aligned(size_q, lsb_q)) begin
                        state_q <= REQ;
                        stb_q   <= 1'b1;
                     end else begin
                        state_q    <= IDLE;
                        misalign_q <= 1'b1;
                     end
                  end
               end
            end
            REQ: begin
               if (wb.i_wb_ack) begin
                  state_q <= IDLE;
                  stb_q   <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               stb_q   <= 1'b0;
            end
         endcase
      end
   end

   qerv_stdata_lane u_lane (
      .size_i (size_q),
      .lsb_i  (lsb_q),
      .data_i (data_q),
      .dat_o  (laneDat),
      .sel_o  (laneSel)
   );

   assign wb.o_wb_stb = stb_q;
   assign wb.o_wb_dat = laneDat;
   assign wb.o_wb_sel = stb_q ? laneSel : 4'b0000;
   assign o_busy      = (state_q != IDLE);
   assign o_done      = done_q;
   assign o_misalign  = misalign_q;

endmodule

// File: tb/tb_qerv_stdata.sv
// Scoreboard bench for qerv_stdata: a driver predicts each store's bus write or
// misalign drop, and an independent monitor checks what the DUT presents.
module tb_qerv_stdata;
   import qerv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        cntEn = 1'b0;
   logic        cntDone = 1'b0;
   logic [3:0]  dat = 4'h0;
   logic [1:0]  size = 2'b00;
   logic [1:0]  lsb = 2'b00;
   logic        busy;
   logic        done;
   logic        misalign;

   qerv_stdata_if bus();

   qerv_stdata dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_cnt_en   (cntEn),
      .i_cnt_done (cntDone),
      .i_dat      (dat),
      .i_size     (size),
      .i_lsb      (lsb),
      .wb         (bus),
      .o_busy     (busy),
      .o_done     (done),
      .o_misalign (misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          isMis;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          cyc;
      int          len;
   } exp_t;

   exp_t        expQ[$];
   exp_t        cur;
   logic [3:0]  nq[$];
   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   bit          rstPrev = 1'b0;
   bit          monOn = 1'b0;
   bit          ackAlways = 1'b0;
   int          curDelay = 0;
   logic [31:0] mdlData = 32'h0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rstPrev <= rst;
   end

   function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Memory-side responder: acks after curDelay stb cycles, or constantly, and
   // drives random acks while no request is outstanding.
   initial begin
      int ackCnt;
      ackCnt = 0;
      bus.i_wb_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (ackAlways) begin
            bus.i_wb_ack = 1'b1;
            ackCnt = 0;
         end else if (bus.o_wb_stb) begin
            bus.i_wb_ack = (ackCnt == curDelay);
            ackCnt++;
         end else begin
            bus.i_wb_ack = 1'($urandom_range(0, 1));
            ackCnt = 0;
         end
      end
   end

   // Monitor: pops a prediction whenever a write request starts or a store is dropped.
   initial begin
      bit inStb;
      int stbLen;
      exp_t m;
      inStb = 1'b0;
      stbLen = 0;
      forever begin
         @(negedge clk);
         if (monOn) begin
            if (rstPrev) begin
               checkOutput("rst_stb", 32'(bus.o_wb_stb), 32'd0);
               checkOutput("rst_done", 32'(done), 32'd0);
               checkOutput("rst_misalign", 32'(misalign), 32'd0);
               checkOutput("rst_busy", 32'(busy), 32'd0);
               checkOutput("rst_sel", 32'(bus.o_wb_sel), 32'd0);
               inStb = 1'b0;
            end else begin
               if (bus.o_wb_stb) begin
                  checkOutput("busy_in_req", 32'(busy), 32'd1);
                  checkOutput("done_in_req", 32'(done), 32'd0);
                  if (!inStb) begin
                     if (expQ.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL stb_unexpected: got stb=1, expected no request (cycle %0d)", cyc);
                     end else begin
                        cur = expQ.pop_front();
                        checkOutput("req_kind_misalign", 32'(cur.isMis), 32'd0);
                        checkOutput("stb_latency_cycle", 32'(cyc), 32'(cur.cyc));
                        checkOutput("wb_dat", bus.o_wb_dat, cur.dat);
                        checkOutput("wb_sel", 32'(bus.o_wb_sel), 32'(cur.sel));
                     end
                     inStb = 1'b1;
                     stbLen = 1;
                  end else begin
                     stbLen++;
                     checkOutput("wb_dat_stable", bus.o_wb_dat, cur.dat);
                     checkOutput("wb_sel_stable", 32'(bus.o_wb_sel), 32'(cur.sel));
                  end
               end else begin
                  checkOutput("sel_outside_req", 32'(bus.o_wb_sel), 32'd0);
                  if (inStb) begin
                     inStb = 1'b0;
                     if (cur.len > 0) checkOutput("stb_length", 32'(stbLen), 32'(cur.len));
                     checkOutput("done_pulse", 32'(done), 32'd1);
                  end else begin
                     checkOutput("done_spurious", 32'(done), 32'd0);
                  end
               end
               if (misalign) begin
                  checkOutput("misalign_stb", 32'(bus.o_wb_stb), 32'd0);
                  if (expQ.size() == 0) begin
                     compared++;
                     mismatched++;
                     $display("[TB] FAIL misalign_unexpected: got misalign=1, expected none (cycle %0d)", cyc);
                  end else begin
                     m = expQ.pop_front();
                     checkOutput("drop_kind_misalign", 32'(m.isMis), 32'd1);
                     checkOutput("misalign_cycle", 32'(cyc), 32'(m.cyc));
                  end
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic loadNibbles(input logic [31:0] value, input int n);
      nq.delete();
      for (int i = 0; i < n; i++) nq.push_back(4'((value >> (4 * (i % 8))) & 32'hF));
   endtask

   // Issues one store of the nibbles in nq. delay<0 means ack held high; abortFill>0
   // resets after that many nibbles; abortReq resets while the request is pending.
   task automatic applyStimulus(input logic [1:0] sz, input logic [1:0] lo, input int delay,
                                input int abortFill, input bit abortReq);
      exp_t e;
      bit   aligned;
      if (delay < 0) ackAlways = 1'b1;
      else begin
         ackAlways = 1'b0;
         curDelay = delay;
      end
      start = 1'b1;
      size = sz;
      lsb = lo;
      cntEn = 1'($urandom);
      cntDone = 1'($urandom);
      dat = 4'($urandom);
      tick();
      start = 1'b0;
      size = 2'($urandom);
      lsb = 2'($urandom);
      for (int k = 0; k < nq.size(); k++) begin
         while ($urandom_range(0, 3) == 0) begin
            cntEn = 1'b0;
            cntDone = 1'($urandom);
            dat = 4'($urandom);
            start = 1'($urandom);
            tick();
         end
         cntEn = 1'b1;
         dat = nq[k];
         cntDone = (k == nq.size() - 1);
         start = 1'($urandom);
         mdlData = {nq[k], mdlData[31:4]};
         if (cntDone) begin
            aligned = (sz == QERV_SZ_B) ? 1'b1 : (sz == QERV_SZ_H) ? (lo % 2 == 0) : (lo == 2'b00);
            e.isMis = !aligned;
            e.cyc = cyc + 1;
            e.len = abortReq ? -1 : (delay < 0 ? 1 : delay + 1);
            if (sz == QERV_SZ_B) begin
               e.dat = (mdlData & 32'hFF) * 32'h01010101;
               e.sel = 4'(1 << lo);
            end else if (sz == QERV_SZ_H) begin
               e.dat = (mdlData & 32'hFFFF) * 32'h00010001;
               e.sel = (lo >= 2) ? 4'b1100 : 4'b0011;
            end else begin
               e.dat = mdlData;
               e.sel = 4'b1111;
            end
            expQ.push_back(e);
         end
         tick();
         if (abortFill == k + 1) begin
            cntEn = 1'b0;
            cntDone = 1'b0;
            start = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            mdlData = 32'h0;
            return;
         end
      end
      cntEn = 1'b0;
      cntDone = 1'b0;
      start = 1'b0;
      if (abortReq) begin
         repeat (3) tick();
         rst = 1'b1;
         tick();
         rst = 1'b0;
         mdlData = 32'h0;
         return;
      end
      for (int w = 0; w < 40 && busy; w++) begin
         cntEn = 1'($urandom);
         cntDone = 1'($urandom);
         dat = 4'($urandom);
         start = 1'($urandom);
         tick();
      end
      checkOutput("return_to_idle", 32'(busy), 32'd0);
      cntEn = 1'b0;
      cntDone = 1'b0;
      start = 1'b0;
      tick();
   endtask

   initial begin
      int n;
      int dly;
      int abF;
      bit abR;
      logic [31:0] v;
      tick();
      monOn = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      loadNibbles(32'h12345678, 8);
      applyStimulus(QERV_SZ_W, 2'b00, 2, 0, 1'b0);
      loadNibbles(32'h0000005A, 8);
      applyStimulus(QERV_SZ_B, 2'b11, 0, 0, 1'b0);
      loadNibbles(32'h0000BEEF, 8);
      applyStimulus(QERV_SZ_H, 2'b10, 1, 0, 1'b0);
      loadNibbles(32'h0000BEEF, 8);
      applyStimulus(QERV_SZ_H, 2'b01, 0, 0, 1'b0);
      loadNibbles(32'h89ABCDEF, 8);
      applyStimulus(QERV_SZ_W, 2'b00, -1, 0, 1'b0);
      loadNibbles(32'h11112222, 8);
      applyStimulus(QERV_SZ_W, 2'b00, 1, 4, 1'b0);
      loadNibbles(32'hCAFEF00D, 8);
      applyStimulus(QERV_SZ_W, 2'b00, 1, 0, 1'b0);
      loadNibbles(32'h0F0F0F0F, 8);
      applyStimulus(QERV_SZ_W, 2'b00, 1000, 0, 1'b1);
      loadNibbles(32'h00A1B2C3, 6);
      applyStimulus(2'b11, 2'b00, 0, 0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         n = $urandom_range(1, 10);
         v = $urandom;
         loadNibbles(v, n);
         dly = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 3);
         abF = (n >= 2 && $urandom_range(0, 7) == 0) ? $urandom_range(1, n - 1) : 0;
         abR = (abF == 0 && $urandom_range(0, 9) == 0);
         applyStimulus(2'($urandom), 2'($urandom), abR ? 1000 : dly, abF, abR);
      end

      ackAlways = 1'b0;
      repeat (5) tick();
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
